interrupt_controller: RTL and testbench

//  Bus-mapped interrupt controller between peripheral IRQ sources and the processor's 2-line interrupt interface.

---
 rtl/interrupt_controller_if.sv | 22 ++
 rtl/interrupt_controller.sv | 127 ++++++++++++
 tb/tb_interrupt_controller.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// Processor-side and source-side signals of the interrupt controller, minus the tristate data bus.
// master = CPU/peripheral side that drives requests; slave = controller.
interface interrupt_controller_if #(
    parameter int NUM_SRC = 4
);
    logic [7:0]         bus_addr;
    logic               bus_we;
    logic [NUM_SRC-1:0] src_irq;
    logic [NUM_SRC-1:0] src_ack;
    logic [1:0]         cpu_irq_raise;
    logic [1:0]         cpu_irq_ack;

    modport master (
        output bus_addr, bus_we, src_irq, cpu_irq_ack,
        input  src_ack, cpu_irq_raise
    );

    modport slave (
        input  bus_addr, bus_we, src_irq, cpu_irq_ack,
        output src_ack, cpu_irq_raise
    );
endinterface

// File: rtl/interrupt_controller.sv
// Bus-mapped interrupt controller: edge-latched PENDING, MASK, ROUTE to two CPU lines,
// round-robin pick per line, raise held until CPU ack; read data appears the cycle after the address.
module interrupt_controller #(
    parameter int          NUM_SRC   = 4,
    parameter logic [7:0]  BASE_ADDR = 8'hE0
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    interrupt_controller_if.slave   io_bus,
    inout  wire  [7:0]              io_bus_data
);
    typedef enum logic [1:0] {L_IDLE, L_RAISE, L_GAP} line_state_t;

    logic [NUM_SRC-1:0] r_pending, r_mask, r_route, r_irq_prev, r_src_ack;
    logic [7:0]         r_id, r_rd_dat;
    logic               r_rd_oe;
    line_state_t        r_state [2];
    logic [2:0]         r_win   [2];
    logic [2:0]         r_ptr   [2];

    line_state_t        w_state_nxt [2];
    logic [NUM_SRC-1:0] w_elig      [2];
    logic [2:0]         w_pick      [2];
    logic               w_pick_vld  [2];
    logic               w_take      [2];
    logic [NUM_SRC-1:0] w_ack_clr, w_edge, w_w1c, w_wdat;
    logic [7:0]         w_off, w_rd_val;
    logic               w_hit, w_wr, w_rd;
    logic               w_unused;

    assign w_off    = io_bus.bus_addr - BASE_ADDR;
    assign w_hit    = (w_off < 8'd4);
    assign w_wr     = w_hit &  io_bus.bus_we;
    assign w_rd     = w_hit & ~io_bus.bus_we;
    assign w_wdat   = io_bus_data[NUM_SRC-1:0];
    assign w_unused = ^io_bus_data;

    assign w_edge = io_bus.src_irq & ~r_irq_prev;
    assign w_w1c  = (w_wr && w_off == 8'd0) ? w_wdat : '0;

    assign io_bus_data          = r_rd_oe ? r_rd_dat : 8'hzz;
    assign io_bus.src_ack       = r_src_ack;
    assign io_bus.cpu_irq_raise = {r_state[1] == L_RAISE, r_state[0] == L_RAISE};

    always_comb begin
        w_rd_val = 8'h00;
        case (w_off[1:0])
            2'd0:    w_rd_val = 8'(r_pending);
            2'd1:    w_rd_val = 8'(r_mask);
            2'd2:    w_rd_val = 8'(r_route);
            default: w_rd_val = r_id;
        endcase
    end

    // Nearest eligible index after ptr wins; scanning far-to-near lets the nearest overwrite.
    function automatic logic [3:0] rr_pick(input logic [NUM_SRC-1:0] elig, input logic [2:0] ptr);
        logic [3:0] res;
        int         idx;
        res = 4'h0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_SRC;
            if (elig[idx]) res = {1'b1, 3'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            w_elig[l] = r_pending & r_mask & ((l == 0) ? ~r_route : r_route);
            // A source already held by the other line must not be granted twice after a ROUTE change.
            if (r_state[1-l] == L_RAISE)
                w_elig[l] = w_elig[l] & ~(NUM_SRC'(1) << r_win[1-l]);
            {w_pick_vld[l], w_pick[l]} = rr_pick(w_elig[l], r_ptr[l]);
            w_state_nxt[l] = r_state[l];
            w_take[l]      = 1'b0;
            case (r_state[l])
                L_IDLE:  if (w_pick_vld[l]) w_state_nxt[l] = L_RAISE;
                L_RAISE: if (io_bus.cpu_irq_ack[l]) begin
                    w_state_nxt[l] = L_GAP;
                    w_take[l]      = 1'b1;
                end
                L_GAP:   w_state_nxt[l] = L_IDLE;
                default: w_state_nxt[l] = L_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ack_clr = '0;
        for (int l = 0; l < 2; l++)
            if (w_take[l]) w_ack_clr = w_ack_clr | (NUM_SRC'(1) << r_win[l]);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pending  <= '0;
            r_mask     <= '0;
            r_route    <= '0;
            r_irq_prev <= '0;
            r_src_ack  <= '0;
            r_id       <= 8'h00;
            r_rd_oe    <= 1'b0;
            r_rd_dat   <= 8'h00;
            for (int l = 0; l < 2; l++) begin
                r_state[l] <= L_IDLE;
                r_win[l]   <= 3'd0;
                r_ptr[l]   <= 3'(NUM_SRC - 1);
            end
        end else begin
            r_irq_prev <= io_bus.src_irq;
            // New edge beats a same-cycle W1C or ack clear.
            r_pending  <= (r_pending & ~w_w1c & ~w_ack_clr) | w_edge;
            if (w_wr && w_off == 8'd1) r_mask  <= w_wdat;
            if (w_wr && w_off == 8'd2) r_route <= w_wdat;
            r_rd_oe   <= w_rd;
            r_rd_dat  <= w_rd_val;
            r_src_ack <= w_ack_clr;
            if (w_take[0]) r_id[3:0] <= {1'b0, r_win[0]};
            if (w_take[1]) r_id[7:4] <= {1'b0, r_win[1]};
            for (int l = 0; l < 2; l++) begin
                r_state[l] <= w_state_nxt[l];
                if (r_state[l] == L_IDLE && w_pick_vld[l]) r_win[l] <= w_pick[l];
                if (w_take[l]) r_ptr[l] <= r_win[l];
            end
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed stimulus pushes expected reads, SRC_ACK pulses and RAISE samples into queues;
// a negedge monitor pops and compares whenever the DUT presents that output.
module tb_interrupt_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       r_drv_en;
    logic [7:0] r_drv_dat;
    wire  [7:0] w_bus_data;
    logic       r_chk = 1'b0, r_tmo = 1'b0, r_done = 1'b0, r_rd_seen = 1'b0;
    int         total = 0, bad = 0;
    logic [7:0] rd_q [$];
    logic [3:0] ack_q [$];
    logic [1:0] raise_q [$];
    logic [7:0] e8;
    logic [3:0] e4;
    logic [1:0] e2;

    always #5 clk = ~clk;

    assign w_bus_data = r_drv_en ? r_drv_dat : 8'hzz;

    interrupt_controller_if #(.NUM_SRC(4)) bus ();

    interrupt_controller #(.NUM_SRC(4), .BASE_ADDR(8'hE0)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .io_bus     (bus),
        .io_bus_data(w_bus_data)
    );

    always @(negedge clk) begin
        if (r_rd_seen) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected got=%h", w_bus_data);
            end else begin
                e8 = rd_q.pop_front();
                if (w_bus_data !== e8) begin
                    bad++;
                    $display("FAIL rd_data got=%h exp=%h t=%0t", w_bus_data, e8, $time);
                end
            end
        end
        r_rd_seen <= rst_n && !bus.bus_we && bus.bus_addr >= 8'hE0 && bus.bus_addr <= 8'hE3;
        if (bus.src_ack != 4'h0) begin
            total++;
            if (ack_q.size() == 0) begin
                bad++;
                $display("FAIL src_ack_unexpected got=%b", bus.src_ack);
            end else begin
                e4 = ack_q.pop_front();
                if (bus.src_ack !== e4) begin
                    bad++;
                    $display("FAIL src_ack got=%b exp=%b t=%0t", bus.src_ack, e4, $time);
                end
            end
        end
        if (r_chk) begin
            total++;
            e2 = raise_q.pop_front();
            if (bus.cpu_irq_raise !== e2) begin
                bad++;
                $display("FAIL raise got=%b exp=%b t=%0t", bus.cpu_irq_raise, e2, $time);
            end
        end
        if (r_tmo) begin
            total++;
            bad++;
            $display("FAIL raise_timeout got=%b exp=raised t=%0t", bus.cpu_irq_raise, $time);
        end
        if (r_done) begin
            total++;
            if (rd_q.size() + ack_q.size() + raise_q.size() != 0) begin
                bad++;
                $display("FAIL leftover got=%0d exp=0 (rd=%0d ack=%0d raise=%0d)",
                         rd_q.size() + ack_q.size() + raise_q.size(),
                         rd_q.size(), ack_q.size(), raise_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.bus_addr = a; bus.bus_we = 1'b1; r_drv_en = 1'b1; r_drv_dat = d;
        cyc();
        bus.bus_addr = 8'h00; bus.bus_we = 1'b0; r_drv_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        rd_q.push_back(e);
        bus.bus_addr = a; bus.bus_we = 1'b0;
        cyc();
        bus.bus_addr = 8'h00;
        cyc();
    endtask

    task automatic chk_raise(input logic [1:0] e);
        raise_q.push_back(e);
        r_chk = 1'b1;
        cyc();
        r_chk = 1'b0;
    endtask

    task automatic wait_raise(input int line, input int budget);
        int n;
        n = 0;
        while (!bus.cpu_irq_raise[line] && n < budget) begin
            cyc();
            n++;
        end
        if (!bus.cpu_irq_raise[line]) begin
            r_tmo = 1'b1;
            cyc();
            r_tmo = 1'b0;
        end
    endtask

    task automatic ack(input int line, input logic [3:0] e);
        ack_q.push_back(e);
        bus.cpu_irq_ack[line] = 1'b1;
        cyc();
        bus.cpu_irq_ack = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.src_irq = 4'h0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; r_drv_en = 1'b0; r_drv_dat = 8'h00;
        bus.bus_addr = 8'h00; bus.bus_we = 1'b0;
        bus.src_irq = 4'hF; bus.cpu_irq_ack = 2'b00;

        // Reset with all sources high; drop them before release so no edge is seen afterwards.
        cyc();
        chk_raise(2'b00);
        bus.src_irq = 4'h0;
        cyc();
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) rd(8'hE0 + 8'(a), 8'h00);

        // Single source on line 0.
        wr(8'hE1, 8'h01);
        bus.src_irq = 4'h1;
        wait_raise(0, 6);
        rd(8'hE0, 8'h01);
        rd(8'hE3, 8'h00);
        ack(0, 4'b0001);
        chk_raise(2'b00);
        rd(8'hE0, 8'h00);
        rd(8'hE3, 8'h00);
        bus.src_irq = 4'h0;

        // Round-robin from reset pointer.
        do_reset();
        wr(8'hE1, 8'h0F);
        bus.src_irq = 4'hF;
        for (int i = 0; i < 4; i++) begin
            wait_raise(0, 6);
            ack(0, 4'(1 << i));
            rd(8'hE3, 8'(i));
        end
        bus.src_irq = 4'h0;
        cyc();
        bus.src_irq = 4'h3;
        wait_raise(0, 6);
        ack(0, 4'b0001);
        wait_raise(0, 6);
        ack(0, 4'b0010);
        rd(8'hE3, 8'h01);
        rd(8'hE0, 8'h00);
        bus.src_irq = 4'h0;

        // Routing: sources 1,3 on line 1.
        do_reset();
        wr(8'hE1, 8'h0F);
        wr(8'hE2, 8'h0A);
        bus.src_irq = 4'hF;
        wait_raise(0, 6);
        wait_raise(1, 6);
        chk_raise(2'b11);
        ack(1, 4'b0010);
        chk_raise(2'b01);
        rd(8'hE3, 8'h10);
        ack(0, 4'b0001);
        rd(8'hE3, 8'h10);
        wait_raise(1, 6);
        ack(1, 4'b1000);
        wait_raise(0, 6);
        ack(0, 4'b0100);
        rd(8'hE3, 8'h32);
        rd(8'hE0, 8'h00);
        bus.src_irq = 4'h0;

        // Edge wins over same-cycle W1C; unimplemented bits and ID writes.
        do_reset();
        bus.src_irq = 4'h1;
        cyc();
        rd(8'hE0, 8'h01);
        bus.src_irq = 4'h0;
        cyc();
        bus.src_irq = 4'h1;
        wr(8'hE0, 8'h01);
        rd(8'hE0, 8'h01);
        wr(8'hE0, 8'h01);
        rd(8'hE0, 8'h00);
        wr(8'hE2, 8'hFF);
        rd(8'hE2, 8'h0F);
        wr(8'hE3, 8'h55);
        rd(8'hE3, 8'h00);
        rd(8'hE1, 8'h00);
        wr(8'hE2, 8'h00);
        bus.src_irq = 4'h0;

        // Masked pending, late enable, mask removal does not withdraw raise.
        do_reset();
        bus.src_irq = 4'h4;
        cyc();
        rd(8'hE0, 8'h04);
        chk_raise(2'b00);
        wr(8'hE1, 8'h04);
        wait_raise(0, 6);
        wr(8'hE1, 8'h00);
        chk_raise(2'b01);
        rd(8'hE1, 8'h00);
        chk_raise(2'b01);
        bus.cpu_irq_ack[1] = 1'b1;
        cyc();
        bus.cpu_irq_ack = 2'b00;
        chk_raise(2'b01);
        ack(0, 4'b0100);
        chk_raise(2'b00);
        rd(8'hE0, 8'h00);
        rd(8'hE3, 8'h02);

        // Reset while raised drops the line at that edge.
        wr(8'hE1, 8'h04);
        bus.src_irq = 4'h0;
        cyc();
        bus.src_irq = 4'h4;
        wait_raise(0, 6);
        rst_n = 1'b0;
        cyc();
        chk_raise(2'b00);
        do_reset();
        rd(8'hE0, 8'h00);
        rd(8'hE1, 8'h00);

        cyc();
        cyc();
        r_done = 1'b1;
    end
endmodule
